// File: rtl/lm32_wb_arbiter.sv
`default_nettype none
// ============================================================================
// lm32_wb_arbiter : shares one Wishbone slave between the LM32 instruction
//                   (m0) and data (m1) buses, with a per-transfer watchdog.
// Revision        : 1.0
// ============================================================================
module lm32_wb_arbiter #(
  parameter int RR      = 1,
  parameter int TIMEOUT = 255
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  // instruction master
  input  logic [31:0] m0_adr,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  output logic        m0_ack,
  output logic        m0_err,
  // data master
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_dat_w,
  input  logic [3:0]  m1_sel,
  input  logic        m1_we,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m_dat_r,
  // shared slave
  output logic [31:0] s_adr,
  output logic [31:0] s_dat_w,
  output logic [3:0]  s_sel,
  output logic        s_we,
  output logic        s_cyc,
  output logic        s_stb,
  input  logic        s_ack,
  input  logic [31:0] s_dat_r,
  output logic [1:0]  gnt
);

  // One-hot encoding lets the state register double as the grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_e;

  localparam logic [15:0] C_TO_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        last_q,  last_d;
  logic [15:0] tmo_q,   tmo_d;
  logic        err_q,   err_d;
  logic        xfer;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      tmo_q   <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc && m1_cyc)
          state_d = ((RR != 0) && last_q) ? G0 : G1;
        else if (m0_cyc)
          state_d = G0;
        else if (m1_cyc)
          state_d = G1;
      end
      G0: begin
        if (!m0_cyc)
          state_d = m1_cyc ? G1 : IDLE;
      end
      G1: begin
        if (!m1_cyc)
          state_d = m0_cyc ? G0 : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == G0 && state_q != G0)
      last_d = 1'b0;
    if (state_d == G1 && state_q != G1)
      last_d = 1'b1;
  end

  // The instruction master is a full-word reader, so its write side is tied off.
  always_comb begin
    s_adr   = 32'd0;
    s_dat_w = 32'd0;
    s_sel   = 4'd0;
    s_we    = 1'b0;
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    unique case (state_q)
      G0: begin
        s_adr = m0_adr;
        s_sel = 4'hF;
        s_cyc = m0_cyc;
        s_stb = m0_stb & ~err_q;
      end
      G1: begin
        s_adr   = m1_adr;
        s_dat_w = m1_dat_w;
        s_sel   = m1_sel;
        s_we    = m1_we;
        s_cyc   = m1_cyc;
        s_stb   = m1_stb & ~err_q;
      end
      default: ;
    endcase
  end

  assign xfer = s_cyc & s_stb;

  // An ack arriving in the expiry cycle takes precedence over the error.
  always_comb begin
    tmo_d = tmo_q + 16'd1;
    err_d = 1'b0;
    if (!xfer || s_ack || (state_d != state_q)) begin
      tmo_d = 16'd0;
    end else if (tmo_q == C_TO_LAST) begin
      tmo_d = 16'd0;
      err_d = 1'b1;
    end
  end

  assign gnt     = state_q;
  assign m0_ack  = s_ack & state_q[0];
  assign m1_ack  = s_ack & state_q[1];
  assign m0_err  = err_q & state_q[0];
  assign m1_err  = err_q & state_q[1];
  assign m_dat_r = s_dat_r;

endmodule
`default_nettype wire

// File: tb/tb_lm32_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_lm32_wb_arbiter : directed and randomized checks of lm32_wb_arbiter
// Revision           : 1.0
// ============================================================================
module tb_lm32_wb_arbiter;
  localparam int TMO = 8;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [31:0] m0_adr    = 32'd0;
  logic        m0_cyc    = 1'b0;
  logic        m0_stb    = 1'b0;
  logic [31:0] m1_adr    = 32'd0;
  logic [31:0] m1_dat_w  = 32'd0;
  logic [3:0]  m1_sel    = 4'd0;
  logic        m1_we     = 1'b0;
  logic        m1_cyc    = 1'b0;
  logic        m1_stb    = 1'b0;
  logic        s_ack     = 1'b0;
  logic [31:0] s_dat_r   = 32'd0;

  // index 0: RR=1, index 1: RR=0
  logic        m0_ack [2];
  logic        m0_err [2];
  logic        m1_ack [2];
  logic        m1_err [2];
  logic [31:0] m_dat_r [2];
  logic [31:0] s_adr [2];
  logic [31:0] s_dat_w [2];
  logic [3:0]  s_sel [2];
  logic        s_we [2];
  logic        s_cyc [2];
  logic        s_stb [2];
  logic [1:0]  gnt [2];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    lm32_wb_arbiter #(.RR((g == 0) ? 1 : 0), .TIMEOUT(TMO)) u_dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .m0_adr(m0_adr), .m0_cyc(m0_cyc), .m0_stb(m0_stb),
      .m0_ack(m0_ack[g]), .m0_err(m0_err[g]),
      .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_sel(m1_sel), .m1_we(m1_we),
      .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_ack(m1_ack[g]), .m1_err(m1_err[g]),
      .m_dat_r(m_dat_r[g]),
      .s_adr(s_adr[g]), .s_dat_w(s_dat_w[g]), .s_sel(s_sel[g]), .s_we(s_we[g]),
      .s_cyc(s_cyc[g]), .s_stb(s_stb[g]), .s_ack(s_ack), .s_dat_r(s_dat_r),
      .gnt(gnt[g])
    );
  end

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    s_ack  = 1'b0;
  endtask

  // Reference model: who owns the slave, who was served last, how many
  // consecutive cycles the owner's strobe has waited, and whether this cycle
  // carries the watchdog error.
  int owner [2] = '{-1, -1};
  int last  [2] = '{0, 0};
  int waited[2] = '{0, 0};
  bit errnow[2] = '{1'b0, 1'b0};
  bit mvalid    = 1'b0;

  always @(negedge sys_clk) begin : p_model
    logic [108:0] e_v, a_v;
    logic [1:0]   e_gnt;
    logic [31:0]  e_adr, e_dw;
    logic [3:0]   e_sel;
    logic         e_we, e_cyc, e_stb;
    logic         c [2];
    logic         s [2];
    int           nown;
    bit           act, nerr;
    c[0] = m0_cyc; c[1] = m1_cyc;
    s[0] = m0_stb; s[1] = m1_stb;
    for (int d = 0; d < 2; d++) begin
      if (mvalid) begin
        e_gnt = (owner[d] == 0) ? 2'b01 : (owner[d] == 1) ? 2'b10 : 2'b00;
        e_adr = 32'd0; e_dw = 32'd0; e_sel = 4'd0; e_we = 1'b0; e_cyc = 1'b0; e_stb = 1'b0;
        if (owner[d] == 0) begin
          e_adr = m0_adr; e_sel = 4'hF; e_cyc = m0_cyc; e_stb = m0_stb && !errnow[d];
        end else if (owner[d] == 1) begin
          e_adr = m1_adr; e_dw = m1_dat_w; e_sel = m1_sel; e_we = m1_we;
          e_cyc = m1_cyc; e_stb = m1_stb && !errnow[d];
        end
        e_v = {e_gnt, s_ack && owner[d] == 0, errnow[d] && owner[d] == 0,
               s_ack && owner[d] == 1, errnow[d] && owner[d] == 1,
               s_dat_r, e_adr, e_dw, e_sel, e_we, e_cyc, e_stb};
        a_v = {gnt[d], m0_ack[d], m0_err[d], m1_ack[d], m1_err[d], m_dat_r[d],
               s_adr[d], s_dat_w[d], s_sel[d], s_we[d], s_cyc[d], s_stb[d]};
        n_checks++;
        if (a_v !== e_v) begin
          n_errors++;
          $display("FAIL model_dut%0d: got %h expected %h at %0t", d, a_v, e_v, $time);
        end
      end
      if (!sys_rst_n) begin
        owner[d] = -1; last[d] = 0; waited[d] = 0; errnow[d] = 1'b0;
      end else begin
        act  = (owner[d] >= 0) && c[owner[d]] && s[owner[d]] && !errnow[d];
        nerr = 1'b0;
        if (act && !s_ack) begin
          waited[d]++;
          if (waited[d] == TMO) begin
            nerr = 1'b1;
            waited[d] = 0;
          end
        end else begin
          waited[d] = 0;
        end
        nown = owner[d];
        if (owner[d] < 0) begin
          if (c[0] && c[1])      nown = (d == 0) ? 1 - last[d] : 1;
          else if (c[0])         nown = 0;
          else if (c[1])         nown = 1;
        end else if (!c[owner[d]]) begin
          nown = c[1 - owner[d]] ? 1 - owner[d] : -1;
        end
        if (nown != owner[d]) begin
          waited[d] = 0;
          if (nown >= 0) last[d] = nown;
        end
        owner[d]  = nown;
        errnow[d] = nerr;
      end
    end
    if (!sys_rst_n) mvalid = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    logic ack0, ack1;
    int   ack_pct;

    // Reset with both masters requesting and the slave acking.
    sys_rst_n = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1; s_ack = 1'b1;
    tick(); tick(); tick();
    @(negedge sys_clk);
    chk("rst_gnt", gnt[0], 2'b00);
    chk("rst_scyc", s_cyc[0], 1'b0);
    chk("rst_m0ack", m0_ack[0], 1'b0);
    chk("rst_m1ack", m1_ack[1], 1'b0);
    tick();
    sys_rst_n = 1'b1; s_ack = 1'b0;
    tick();
    @(negedge sys_clk);
    chk("post_rst_gnt_rr1", gnt[0], 2'b10);
    chk("post_rst_gnt_rr0", gnt[1], 2'b10);
    tick();
    idle_inputs();
    tick();

    // Single read on m0.
    m0_adr = 32'h100; m0_cyc = 1'b1; m0_stb = 1'b1;
    tick();
    @(negedge sys_clk);
    chk("rd_gnt", gnt[0], 2'b01);
    chk("rd_sadr", s_adr[0], 32'h100);
    chk("rd_swe", s_we[0], 1'b0);
    chk("rd_ssel", s_sel[0], 4'hF);
    chk("rd_sstb", s_stb[0], 1'b1);
    chk("rd_noack", m0_ack[0], 1'b0);
    tick();
    s_ack = 1'b1; s_dat_r = 32'hDEADBEEF;
    @(negedge sys_clk);
    chk("rd_m0ack", m0_ack[0], 1'b1);
    chk("rd_datr", m_dat_r[0], 32'hDEADBEEF);
    chk("rd_m1ack", m1_ack[0], 1'b0);
    tick();
    m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
    @(negedge sys_clk);
    chk("rd_ack_once", m0_ack[0], 1'b0);
    tick();

    // Write on m1.
    m1_adr = 32'hFF000000; m1_dat_w = 32'h41; m1_sel = 4'b0001; m1_we = 1'b1;
    m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    @(negedge sys_clk);
    chk("wr_gnt", gnt[0], 2'b10);
    chk("wr_sadr", s_adr[0], 32'hFF000000);
    chk("wr_sdatw", s_dat_w[0], 32'h41);
    chk("wr_ssel", s_sel[0], 4'b0001);
    chk("wr_swe", s_we[0], 1'b1);
    tick();
    s_ack = 1'b1;
    @(negedge sys_clk);
    chk("wr_m1ack", m1_ack[0], 1'b1);
    chk("wr_m0ack", m0_ack[0], 1'b0);
    tick();
    idle_inputs();
    tick();

    // Round-robin contention: each master drops cyc for one cycle after its ack.
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      #1 s_ack = s_stb[0];
      @(negedge sys_clk);
      chk("rr_alt_gnt", gnt[0], ((i / 2) % 2 == 0) ? 2'b01 : 2'b10);
      ack0 = m0_ack[0];
      ack1 = m1_ack[0];
      tick();
      m0_cyc = !ack0; m0_stb = !ack0;
      m1_cyc = !ack1; m1_stb = !ack1;
    end
    idle_inputs();
    tick();

    // Both request from idle repeatedly: RR=1 alternates, RR=0 always picks m1.
    sys_rst_n = 1'b0;
    tick(); tick();
    sys_rst_n = 1'b1;
    tick();
    for (int r = 0; r < 3; r++) begin
      m0_cyc = 1'b1; m1_cyc = 1'b1;
      tick();
      @(negedge sys_clk);
      chk("fixed_prio_gnt", gnt[1], 2'b10);
      chk("rr_idle_gnt", gnt[0], (r % 2 == 0) ? 2'b10 : 2'b01);
      tick();
      idle_inputs();
      tick();
    end

    // Watchdog: m1 strobes with no slave response.
    m1_adr = 32'h2000; m1_we = 1'b0; m1_cyc = 1'b1; m1_stb = 1'b1; s_ack = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      @(negedge sys_clk);
      chk("tmo_err", m1_err[0], (c == 9) ? 1'b1 : 1'b0);
      chk("tmo_sstb", s_stb[0], (c == 9) ? 1'b0 : 1'b1);
      chk("tmo_noack", m1_ack[0], 1'b0);
      chk("tmo_gnt", gnt[0], 2'b10);
    end
    tick();
    idle_inputs();
    tick();

    // Ack in the would-be expiry cycle wins and restarts the count.
    m1_cyc = 1'b1; m1_stb = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      tick();
      s_ack = (c == 8);
      @(negedge sys_clk);
      if (c == 8) chk("bnd_ack", m1_ack[0], 1'b1);
      chk("bnd_err", m1_err[0], (c == 17) ? 1'b1 : 1'b0);
    end
    tick();
    idle_inputs();
    tick();

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      tick();
      ack_pct   = ((i / 500) % 2 == 0) ? 40 : 8;
      sys_rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 7) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(0, 7) == 0) m1_cyc = ~m1_cyc;
      m0_stb   = m0_cyc && ($urandom_range(0, 3) != 0);
      m1_stb   = m1_cyc && ($urandom_range(0, 3) != 0);
      m0_adr   = $urandom;
      m1_adr   = $urandom;
      m1_dat_w = $urandom;
      m1_sel   = 4'($urandom_range(0, 15));
      m1_we    = 1'($urandom_range(0, 1));
      s_dat_r  = $urandom;
      s_ack    = ($urandom_range(0, 99) < ack_pct);
    end
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lm32_wb_arbiter.md
Name: lm32_wb_arbiter

Overview:
Two-master, one-slave Wishbone arbiter that shares a single 32-bit memory/peripheral slave between the LM32 instruction bus and data bus. It sits between lm32_top and the shared program/data memory in single-port SoC and test configurations. Grants are held for a whole bus cycle (CYC). A per-transfer watchdog terminates hung transfers with ERR.

Parameters:
RR, 1, 1 = round-robin between masters; 0 = fixed priority, data master (m1) wins
TIMEOUT, 255, cycles a granted STB may wait for s_ack before ERR is returned (1..65535)

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst_n  in  1  synchronous, active-low reset
m0_adr  in  32  instruction master address (read-only master, full-word reads)
m0_cyc  in  1  instruction master cycle
m0_stb  in  1  instruction master strobe
m0_ack  out  1  instruction master acknowledge
m0_err  out  1  instruction master error (timeout)
m1_adr  in  32  data master address
m1_dat_w  in  32  data master write data
m1_sel  in  4  data master byte select
m1_we  in  1  data master write enable
m1_cyc  in  1  data master cycle
m1_stb  in  1  data master strobe
m1_ack  out  1  data master acknowledge
m1_err  out  1  data master error (timeout)
m_dat_r  out  32  read data broadcast to both masters (= s_dat_r)
s_adr  out  32  slave address
s_dat_w  out  32  slave write data
s_sel  out  4  slave byte select
s_we  out  1  slave write enable
s_cyc  out  1  slave cycle
s_stb  out  1  slave strobe
s_ack  in  1  slave acknowledge
s_dat_r  in  32  slave read data
gnt  out  2  one-hot current grant {m1,m0}; 00 = idle

Behaviour:
- Reset (sys_rst_n=0 at a clock edge): state IDLE, gnt=00, last-served=m0, timeout counter=0, m0_err=m1_err=0. s_cyc/s_stb/s_we/m*_ack are 0 because grant is 00. Reset mid-transfer drops the transfer immediately; no ack or err is issued.
- FSM states: IDLE, G0 (m0 owns), G1 (m1 owns). gnt is registered and one-hot.
- IDLE: only m0_cyc -> G0; only m1_cyc -> G1; both -> RR=1: the master not served last; RR=0: G1.
- Gx: hold while mx_cyc=1. When mx_cyc=0, go to the other grant state if the other master's cyc=1 (back-to-back, no idle cycle), else IDLE. last-served updates on every grant entry.
- Latency: the master raises cyc/stb in cycle N; gnt is set at edge N+1; s_cyc/s_stb are visible in cycle N+1.
- Slave mux (combinational from gnt): G0: s_adr=m0_adr, s_we=0, s_sel=1111, s_dat_w=0. G1: m1 signals passed through. s_cyc = granted cyc; s_stb = granted stb & ~err_pending. Idle: all s_* = 0.
- Ack routing: mx_ack = s_ack & gnt[x]. The ungranted master never sees ack or err. m_dat_r = s_dat_r always.
- Timeout counter (16 bit): clears on s_ack, on err issue, on grant change, or when s_stb=0. Otherwise it increments each cycle s_cyc&s_stb&~s_ack. When it reaches TIMEOUT-1, the granted master gets mx_err=1 for exactly one cycle, s_stb is masked in that cycle, and the counter clears. s_ack and the timeout in the same cycle: ack wins, no err.
- The grant never changes while granted cyc=1, including across multiple stb beats and after err.
- A master dropping cyc without an ack is legal; release follows the normal rules above.

Test Plan:
- Reset: hold sys_rst_n=0 with m0_cyc=m1_cyc=1 -> gnt=00, s_cyc=0, no ack. After release, gnt=10 at the next edge (RR, last-served reset to m0).
- Single read on m0: m0_adr=0x100, cyc/stb=1, slave acks 1 cycle after s_stb with s_dat_r=0xDEADBEEF -> s_adr=0x100, s_we=0, s_sel=1111, m0_ack pulses once, m_dat_r=0xDEADBEEF, m1_ack=0.
- Write on m1: adr=0xFF000000, dat_w=0x41, sel=0001, we=1 -> identical values on s_*, m1_ack one cycle, gnt=10.
- Contention, RR=1: both masters request continuously, each drops cyc after one ack -> grants alternate 01,10,01,... with no idle cycle between them. Rerun with RR=0 -> m1 always wins while requesting.
- Timeout, TIMEOUT=8: m1 stb with no s_ack -> m1_err for one cycle exactly 8 cycles after s_stb rises, s_stb=0 in that cycle, no m1_ack, grant retained while m1_cyc=1.
- Ack at the timeout boundary: s_ack in cycle 8 with TIMEOUT=8 -> m1_ack=1, m1_err=0, counter cleared.
